// File: rtl/blake_pkg.sv
// Shared types and constants for the BLAKE-512 round scheduler.
package blake_pkg;

  typedef enum logic [1:0] {StIdle, StInit, StRound, StFinal} state_e;

  localparam int unsigned G_TOTAL    = 8;
  localparam int unsigned SIGMA_ROWS = 10;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned SIGMA_W    = 4;

  function automatic int unsigned steps_for(int unsigned g_par);
    return G_TOTAL / g_par;
  endfunction

  // A single-step round still needs a 1-bit step index.
  function automatic int unsigned step_width(int unsigned g_par);
    int unsigned steps;
    steps = G_TOTAL / g_par;
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/blake_round_counter.sv
// Step, round and sigma-row counters for the round scheduler.
module blake_round_counter
  import blake_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned G_PAR      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          advance,
  output logic [ROUND_W-1:0]            round_idx,
  output logic [step_width(G_PAR)-1:0]  step_idx,
  output logic [SIGMA_W-1:0]            sigma_row,
  output logic                          last_step
);

  localparam int unsigned STEPS = steps_for(G_PAR);
  localparam int unsigned SW    = step_width(G_PAR);

  logic [ROUND_W-1:0] round_q;
  logic [SW-1:0]      step_q;
  logic [SIGMA_W-1:0] sigma_q;
  logic               step_wrap;

  assign step_wrap = (step_q == SW'(STEPS - 1));
  assign last_step = step_wrap && (round_q == ROUND_W'(NUM_ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      round_q <= '0;
      step_q  <= '0;
      sigma_q <= '0;
    end else if (advance) begin
      if (step_wrap) begin
        step_q  <= '0;
        round_q <= round_q + ROUND_W'(1);
        // Sigma row tracks round mod 10 without a divider.
        sigma_q <= (sigma_q == SIGMA_W'(SIGMA_ROWS - 1)) ? '0 : sigma_q + SIGMA_W'(1);
      end else begin
        step_q <= step_q + SW'(1);
      end
    end
  end

  assign round_idx = round_q;
  assign step_idx  = step_q;
  assign sigma_row = sigma_q;

endmodule

// File: rtl/blake_round_scheduler.sv
// Sequences one BLAKE-512 compression: init strobe, G-core steps per round, finalize/done.
module blake_round_scheduler
  import blake_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned G_PAR      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stall,
  output logic                          ready,
  output logic                          busy,
  output logic                          init_round,
  output logic                          step_en,
  output logic [ROUND_W-1:0]            round_idx,
  output logic [step_width(G_PAR)-1:0]  step_idx,
  output logic [2:0]                    g_base,
  output logic                          diag,
  output logic [SIGMA_W-1:0]            sigma_row,
  output logic                          finalize,
  output logic                          done
);

  state_e state_q, state_d;
  logic   ready_q, busy_q, init_q, fin_q;
  logic   last_step;
  logic   cnt_clear;

  assign step_en   = (state_q == StRound) && !stall;
  assign cnt_clear = (state_q == StInit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StInit;
      StInit:  state_d = StRound;
      StRound: if (!stall && last_step) state_d = StFinal;
      StFinal: state_d = start ? StInit : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle) || (state_d == StFinal);
      busy_q  <= (state_d != StIdle);
      init_q  <= (state_d == StInit);
      fin_q   <= (state_d == StFinal);
    end
  end

  blake_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .G_PAR      (G_PAR)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .advance    (step_en),
    .round_idx  (round_idx),
    .step_idx   (step_idx),
    .sigma_row  (sigma_row),
    .last_step  (last_step)
  );

  assign g_base     = 3'(32'(step_idx) * G_PAR);
  assign diag       = g_base[2];
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign init_round = init_q;
  assign finalize   = fin_q;
  assign done       = fin_q;

endmodule

// File: tb/tb_blake_round_scheduler.sv
// Scoreboard bench for blake_round_scheduler: default instance plus G_PAR=8, NUM_ROUNDS=14.
module tb_blake_round_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, stall;

  logic       a_ready, a_busy, a_init, a_step_en, a_diag, a_fin, a_done;
  logic [3:0] a_round, a_sigma;
  logic [1:0] a_step;
  logic [2:0] a_gbase;
  logic       b_ready, b_busy, b_init, b_step_en, b_diag, b_fin, b_done;
  logic [3:0] b_round, b_sigma;
  logic [0:0] b_step;
  logic [2:0] b_gbase;

  blake_round_scheduler u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stall(stall),
    .ready(a_ready), .busy(a_busy), .init_round(a_init), .step_en(a_step_en),
    .round_idx(a_round), .step_idx(a_step), .g_base(a_gbase), .diag(a_diag),
    .sigma_row(a_sigma), .finalize(a_fin), .done(a_done)
  );

  blake_round_scheduler #(.NUM_ROUNDS(14), .G_PAR(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stall(stall),
    .ready(b_ready), .busy(b_busy), .init_round(b_init), .step_en(b_step_en),
    .round_idx(b_round), .step_idx(b_step), .g_base(b_gbase), .diag(b_diag),
    .sigma_row(b_sigma), .finalize(b_fin), .done(b_done)
  );

  bit         sel;
  logic       o_ready, o_busy, o_init, o_step_en, o_diag, o_fin, o_done;
  logic [3:0] o_round, o_sigma;
  logic [2:0] o_step, o_gbase;

  always_comb begin
    if (sel) begin
      o_ready = b_ready; o_busy = b_busy; o_init = b_init; o_step_en = b_step_en;
      o_diag = b_diag; o_fin = b_fin; o_done = b_done; o_round = b_round;
      o_sigma = b_sigma; o_step = {2'b00, b_step}; o_gbase = b_gbase;
    end else begin
      o_ready = a_ready; o_busy = a_busy; o_init = a_init; o_step_en = a_step_en;
      o_diag = a_diag; o_fin = a_fin; o_done = a_done; o_round = a_round;
      o_sigma = a_sigma; o_step = {1'b0, a_step}; o_gbase = a_gbase;
    end
  end

  typedef struct packed {
    logic [3:0] r;
    logic [2:0] s;
    logic [2:0] g;
    logic       d;
    logic [3:0] sg;
  } tup_t;

  tup_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  task automatic test_reset();
    bit done_seen;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; stall = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({a_ready, a_busy, a_init, a_step_en, a_fin, a_done} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags_a got %b want 100000",
               {a_ready, a_busy, a_init, a_step_en, a_fin, a_done});
    end
    checks++;
    if ({a_round, a_step, a_sigma} !== 10'd0) begin
      errors++;
      $display("FAIL reset_idx_a got r=%0d s=%0d sg=%0d want 0", a_round, a_step, a_sigma);
    end
    checks++;
    if ({b_ready, b_busy, b_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags_b got %b want 100", {b_ready, b_busy, b_done});
    end
    // Abandon a block mid-ROUND.
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL midround_busy got %b want 1", a_busy);
    end
    rst = 1'b1;
    done_seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (a_done) done_seen = 1'b1;
    end
    rst = 1'b0;
    checks++;
    if ({a_ready, a_busy, a_done, a_round, a_step} !== 9'b100_0000_00) begin
      errors++;
      $display("FAIL midround_reset got rdy=%b busy=%b done=%b r=%0d s=%0d want 1 0 0 0 0",
               a_ready, a_busy, a_done, a_round, a_step);
    end
    repeat (70) begin
      @(posedge clk); #1;
      if (a_done || a_busy) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_block got activity=%b want 0", done_seen);
    end
  endtask

  // Drives one block on the selected DUT, comparing every step against the scoreboard.
  task automatic run_block(input bit use_b, input int nr, input int gpar, input bit do_stall,
                           input int exp_done, input bit hold_start);
    int   steps, n, seen_en, first_en, done_at, stall_left;
    bit   stalled_once;
    tup_t e, g;
    steps = 8 / gpar;
    sel   = use_b;
    for (int r = 0; r < nr; r++) begin
      for (int s = 0; s < steps; s++) begin
        e.r = 4'(r); e.s = 3'(s); e.g = 3'(s * gpar);
        e.d = ((s * gpar) >= 4); e.sg = 4'(r % 10);
        q_exp.push_back(e);
      end
    end
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) begin start_a = 1'b0; start_b = 1'b0; end
    n = 1;
    checks++;
    if ({o_init, o_busy, o_ready} !== 3'b110) begin
      errors++;
      $display("FAIL init_strobe got init/busy/rdy=%b want 110", {o_init, o_busy, o_ready});
    end
    seen_en = 0; first_en = -1; done_at = -1; stall_left = 0; stalled_once = 1'b0;
    while (n < exp_done + 5 && done_at < 0) begin
      @(posedge clk); #1;
      n++;
      if (stall && stall_left == 0) stall = 1'b0;
      if (do_stall && !stalled_once && o_busy && !o_init && !o_fin
          && o_round == 4'd5 && o_step == 3'd2) begin
        stall = 1'b1; stall_left = 3; stalled_once = 1'b1;
      end
      #1;
      if (stall) begin
        checks++;
        if (o_step_en !== 1'b0 || o_round !== 4'd5 || o_step !== 3'd2) begin
          errors++;
          $display("FAIL stall_freeze got en=%b r=%0d s=%0d want 0 5 2",
                   o_step_en, o_round, o_step);
        end
        stall_left--;
      end
      if (o_step_en) begin
        if (first_en < 0) first_en = n;
        seen_en++;
        checks++;
        if (q_exp.size() == 0) begin
          errors++;
          $display("FAIL walk_extra got step at cycle %0d want none", n);
        end else begin
          e = q_exp.pop_front();
          g.r = o_round; g.s = o_step; g.g = o_gbase; g.d = o_diag; g.sg = o_sigma;
          if (g !== e) begin
            errors++;
            $display("FAIL walk got r=%0d s=%0d g=%0d d=%b sg=%0d want r=%0d s=%0d g=%0d d=%b sg=%0d",
                     g.r, g.s, g.g, g.d, g.sg, e.r, e.s, e.g, e.d, e.sg);
          end
        end
      end
      if (o_done) begin
        done_at = n;
        checks++;
        if ({o_fin, o_ready, o_busy} !== 3'b111) begin
          errors++;
          $display("FAIL final_flags got fin/rdy/busy=%b want 111", {o_fin, o_ready, o_busy});
        end
      end
    end
    stall = 1'b0;
    checks++;
    if (done_at != exp_done) begin
      errors++;
      $display("FAIL done_cycle got %0d want %0d", done_at, exp_done);
    end
    checks++;
    if (seen_en != nr * steps || first_en != 2) begin
      errors++;
      $display("FAIL step_count got %0d first %0d want %0d first 2", seen_en, first_en, nr * steps);
    end
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL walk_missing got %0d left want 0", q_exp.size());
    end
    q_exp.delete();
    if (!hold_start) begin
      @(posedge clk); #1;
      checks++;
      if ({o_ready, o_busy, o_done} !== 3'b100) begin
        errors++;
        $display("FAIL back_to_idle got rdy/busy/done=%b want 100", {o_ready, o_busy, o_done});
      end
    end
  endtask

  task automatic test_single_block();
    run_block(1'b0, 16, 2, 1'b0, 66, 1'b0);
  endtask

  task automatic test_stall();
    run_block(1'b0, 16, 2, 1'b1, 69, 1'b0);
  endtask

  // start stays high through ROUND (ignored) and FINAL (accepted back-to-back).
  task automatic test_back_to_back();
    run_block(1'b0, 16, 2, 1'b0, 66, 1'b1);
    run_block(1'b0, 16, 2, 1'b0, 66, 1'b0);
  endtask

  task automatic test_param_sweep();
    run_block(1'b1, 14, 8, 1'b0, 16, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_stall();
    test_back_to_back();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
